// File: rtl/alu.sv
// Registered 32-bit ALU: inverting adder plus eight bitwise ops, with NZCV flags and a one-cycle valid pulse.
// Optional ALU_SHIFT_CARRY_EN: logic ops load C from shifter_carry instead of holding it.
module alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             active,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             invert_a,
    input  logic             invert_b,
    input  logic             is_logic,
    input  logic [2:0]       logic_idx,
    input  logic             cin,
`ifdef ALU_SHIFT_CARRY_EN
    input  logic             shifter_carry,
`endif
    output logic [WIDTH-1:0] result,
    output logic             n,
    output logic             z,
    output logic             c,
    output logic             v,
    output logic             valid
);

    logic [WIDTH-1:0] op_a, op_b, logic_res, res_next;
    logic [WIDTH:0]   sum_ext;
    logic             add_ovf;

    assign op_a    = invert_a ? ~a : a;
    assign op_b    = invert_b ? ~b : b;
    assign sum_ext = {1'b0, op_a} + {1'b0, op_b} + {{WIDTH{1'b0}}, cin};
    // Signed overflow: operands agree in sign but the sum does not.
    assign add_ovf = (op_a[WIDTH-1] == op_b[WIDTH-1]) && (sum_ext[WIDTH-1] != op_a[WIDTH-1]);

    always_comb begin
        logic_res = '0;
        case (logic_idx)
            3'd0:    logic_res = op_a & op_b;
            3'd1:    logic_res = op_a ^ op_b;
            3'd2:    logic_res = op_a | op_b;
            3'd3:    logic_res = op_b;
            3'd4:    logic_res = op_a;
            3'd5:    logic_res = ~(op_a & op_b);
            3'd6:    logic_res = ~(op_a | op_b);
            default: logic_res = ~(op_a ^ op_b);
        endcase
    end

    assign res_next = is_logic ? logic_res : sum_ext[WIDTH-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            result <= '0;
            n      <= 1'b0;
            z      <= 1'b0;
            c      <= 1'b0;
            v      <= 1'b0;
            valid  <= 1'b0;
        end else begin
            valid <= active;
            if (active) begin
                result <= res_next;
                n      <= res_next[WIDTH-1];
                z      <= (res_next == '0);
                if (!is_logic) begin
                    c <= sum_ext[WIDTH];
                    v <= add_ovf;
                end else begin
`ifdef ALU_SHIFT_CARRY_EN
                    c <= shifter_carry;
`else
                    c <= c;
`endif
                end
            end
        end
    end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: directed cases then random ops against an arithmetic reference model.
module tb_alu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        active = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        invert_a = 1'b0, invert_b = 1'b0, is_logic = 1'b0, cin = 1'b0, shifter_carry = 1'b0;
    logic [2:0]  logic_idx = '0;
    logic [31:0] result;
    logic        n, z, c, v, valid;

    alu #(.WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n), .active(active), .a(a), .b(b),
        .invert_a(invert_a), .invert_b(invert_b), .is_logic(is_logic),
        .logic_idx(logic_idx), .cin(cin),
`ifdef ALU_SHIFT_CARRY_EN
        .shifter_carry(shifter_carry),
`endif
        .result(result), .n(n), .z(z), .c(c), .v(v), .valid(valid)
    );

    always #5 clk = ~clk;

    logic [31:0] e_res;
    logic        e_n, e_z, e_c, e_v, e_valid;
    int          checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_all(input string tag);
        chk({tag, "_res"}, result, e_res);
        chk({tag, "_nzcv"}, {28'd0, n, z, c, v}, {28'd0, e_n, e_z, e_c, e_v});
        chk({tag, "_valid"}, {31'd0, valid}, {31'd0, e_valid});
    endtask

    task automatic model_reset();
        e_res = '0; e_n = 0; e_z = 0; e_c = 0; e_v = 0; e_valid = 0;
    endtask

    // Reference: unsigned 64-bit add for carry, signed 64-bit add for overflow.
    task automatic model_op();
        logic [31:0] oa, ob, r;
        logic [63:0] us;
        longint      ss;
        e_valid = active;
        if (!active) return;
        oa = invert_a ? ~a : a;
        ob = invert_b ? ~b : b;
        if (!is_logic) begin
            us = {32'd0, oa} + {32'd0, ob} + {63'd0, cin};
            r  = us[31:0];
            e_c = us[32];
            ss = longint'($signed(oa)) + longint'($signed(ob)) + longint'(cin);
            e_v = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end else begin
            case (logic_idx)
                0: r = oa & ob;
                1: r = oa ^ ob;
                2: r = oa | ob;
                3: r = ob;
                4: r = oa;
                5: r = ~(oa & ob);
                6: r = ~(oa | ob);
                default: r = ~(oa ^ ob);
            endcase
`ifdef ALU_SHIFT_CARRY_EN
            e_c = shifter_carry;
`endif
        end
        e_res = r;
        e_n = r[31];
        e_z = (r == 0);
    endtask

    task automatic step(input string tag, input logic act, input logic [31:0] va, input logic [31:0] vb,
                        input logic ia, input logic ib, input logic il, input logic [2:0] idx,
                        input logic ci, input logic sc);
        @(negedge clk);
        active = act; a = va; b = vb; invert_a = ia; invert_b = ib;
        is_logic = il; logic_idx = idx; cin = ci; shifter_carry = sc;
        model_op();
        @(posedge clk);
        #1;
        chk_all(tag);
    endtask

    initial begin
        model_reset();
        #12 rst_n = 1'b1;
        #1 chk_all("reset_init");

        // async reset mid-cycle after an op
        step("pre_rst", 1, 32'h1234_5678, 32'h1, 0, 0, 0, 0, 0, 0);
        #2 rst_n = 1'b0;
        model_reset();
        #1 chk_all("async_rst");
        @(negedge clk) rst_n = 1'b1;

        step("add", 1, 32'hFFFF_FFF0, 32'h0000_000F, 0, 0, 0, 0, 0, 0);
        chk("add_const", result, 32'hFFFF_FFFF);
        step("add_idle", 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0);
        step("add_wrap", 1, 32'hFFFF_FFF0, 32'h0000_0010, 0, 0, 0, 0, 0, 0);
        chk("wrap_flags", {28'd0, n, z, c, v}, 32'b0110);
        step("eor_carry", 1, 32'hF0F0_F0F0, 32'hFF00_FF00, 0, 0, 1, 1, 0, 0);
        chk("eor_const", result, 32'h0FF0_0FF0);
`ifdef ALU_SHIFT_CARRY_EN
        chk("eor_c", {31'd0, c}, 32'd0);
`else
        chk("eor_c", {31'd0, c}, 32'd1);
`endif
        step("sub", 1, 32'd5, 32'd7, 0, 1, 0, 0, 1, 0);
        chk("sub_const", result, 32'hFFFF_FFFE);
        step("hold1", 0, $urandom, $urandom, 1, 1, 1, 3'd5, 1, 1);
        step("hold2", 0, $urandom, $urandom, 0, 1, 0, 3'd2, 1, 1);
        step("rsb", 1, 32'd3, 32'd10, 1, 0, 0, 0, 1, 0);
        step("ovf", 1, 32'h7FFF_FFFF, 32'h1, 0, 0, 0, 0, 0, 0);
        chk("ovf_v", {31'd0, v}, 32'd1);
        step("and_vhold", 1, 32'hFFFF_FFF0, 32'h0000_000F, 0, 0, 1, 0, 0, 1);
        chk("and_v", {31'd0, v}, 32'd1);
        for (int i = 0; i < 8; i++)
            step("logic_sweep", 1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1, 3'(i), 1'($urandom), 1'($urandom));

        for (int i = 0; i < 300; i++) begin
            logic [31:0] ra, rb;
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            step("rand", 1'($urandom_range(0, 3) != 0), ra, rb, 1'($urandom), 1'($urandom),
                 1'($urandom), 3'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
